// File: rtl/vga_game_pkg.sv
`default_nettype none
// ============================================================================
//  Module : vga_game_pkg
//  Brief  : Shared screen-state encoding, controller codes and pad bit indices
//           for the VGA game screen logic.
//  Rev    : 1.0  initial release
// ============================================================================
package vga_game_pkg;

    // Screen select values double as the sequencer state encoding
    typedef enum logic [1:0] {
        ST_SPLASH = 2'd0,
        ST_PLAY   = 2'd1,
        ST_SAVE   = 2'd2,
        ST_RESULT = 2'd3
    } screen_state_t;

    // One-hot button codes from the processor
    localparam logic [31:0] c_code_start_a = 32'd2;
    localparam logic [31:0] c_code_start_b = 32'd4;
    localparam logic [31:0] c_code_skip    = 32'd8;
    localparam logic [31:0] c_code_abort   = 32'd16;

    // Pad hit flag positions in sensor_input
    localparam int c_pad0_bit = 1;
    localparam int c_pad1_bit = 8;
    localparam int c_pad2_bit = 15;

    // Number of pads that rose on a tick (0..3)
    function automatic logic [1:0] pad_hit_count(input logic [2:0] rises);
        return {1'b0, rises[0]} + {1'b0, rises[1]} + {1'b0, rises[2]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_frame_tick.sv
`default_nettype none
// ============================================================================
//  Module : vga_frame_tick
//  Brief  : Registered falling-edge detector on the active-low vertical sync;
//           produces a one-cycle frame tick.
//  Rev    : 1.0  initial release
// ============================================================================
module vga_frame_tick (
    input  logic iVGA_CLK,
    input  logic iRST_n,
    input  logic i_vs,
    output logic o_tick
);

    logic r_vs;
    logic r_vs_d;

    // Two-stage sync history; reset to 0 so no tick fires until sync was seen high
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_vs   <= 1'b0;
            r_vs_d <= 1'b0;
        end else begin
            r_vs   <= i_vs;
            r_vs_d <= r_vs;
        end
    end

    assign o_tick = r_vs_d & ~r_vs;

endmodule
`default_nettype wire

// File: rtl/vga_screen_sequencer.sv
`default_nettype none
// ============================================================================
//  Module : vga_screen_sequencer
//  Brief  : Game screen sequencer: SPLASH -> PLAY -> SAVE -> RESULT, with
//           frame-based round timer, pad hit scoring and save handshake.
//  Rev    : 1.0  initial release
// ============================================================================
import vga_game_pkg::*;

module vga_screen_sequencer #(
    parameter int GAME_FRAMES   = 1800,
    parameter int RESULT_FRAMES = 300
) (
    input  logic        iVGA_CLK,
    input  logic        iRST_n,
    input  logic        iVS,
    input  logic [31:0] controller,
    input  logic [31:0] sensor_input,
    input  logic        save_ack,
    output logic [1:0]  screen,
    output logic [7:0]  score,
    output logic [10:0] frames_left,
    output logic        save_signal,
    output logic [31:0] sensor_input_to_save
);

    localparam logic [10:0] c_game_frames = 11'(GAME_FRAMES);
    localparam logic [15:0] c_result_last = 16'(RESULT_FRAMES - 1);

    screen_state_t r_state;
    screen_state_t w_next;

    logic        w_tick;
    logic [31:0] r_ctrl;
    logic [2:0]  r_pads;
    logic [2:0]  r_pad_hist;
    logic        r_start_pend;
    logic        r_skip_pend;
    logic        r_abort_pend;
    logic [7:0]  r_score;
    logic [10:0] r_frames_left;
    logic [15:0] r_result_cnt;

    vga_frame_tick u_frame_tick (
        .iVGA_CLK (iVGA_CLK),
        .iRST_n   (iRST_n),
        .i_vs     (iVS),
        .o_tick   (w_tick)
    );

    // Only three pad bits carry information; the rest are deliberately dropped
    logic w_unused_sensor;
    assign w_unused_sensor = ^{sensor_input[31:16], sensor_input[14:9],
                               sensor_input[7:2], sensor_input[0]};

    logic w_is_start;
    logic w_is_skip;
    logic w_is_abort;
    assign w_is_start = (r_ctrl == c_code_start_a) || (r_ctrl == c_code_start_b);
    assign w_is_skip  = (r_ctrl == c_code_skip);
    assign w_is_abort = (r_ctrl == c_code_abort);

    // A code arriving on the tick cycle itself still counts for that tick
    logic w_start_seen;
    logic w_skip_seen;
    logic w_abort_seen;
    assign w_start_seen = r_start_pend | w_is_start;
    assign w_skip_seen  = r_skip_pend  | w_is_skip;
    assign w_abort_seen = r_abort_pend | w_is_abort;

    logic [2:0] w_rises;
    logic [8:0] w_sum;
    logic [7:0] w_score_sat;
    assign w_rises     = r_pads & ~r_pad_hist;
    assign w_sum       = {1'b0, r_score} + {7'd0, pad_hit_count(w_rises)};
    assign w_score_sat = w_sum[8] ? 8'hFF : w_sum[7:0];

    logic w_state_change;
    assign w_state_change = (w_next != r_state);

    // Input sampling: one register stage for controller and pad flags
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_ctrl <= 32'd0;
            r_pads <= 3'd0;
        end else begin
            r_ctrl <= controller;
            r_pads <= {sensor_input[c_pad2_bit], sensor_input[c_pad1_bit],
                       sensor_input[c_pad0_bit]};
        end
    end

    // State register
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) r_state <= ST_SPLASH;
        else         r_state <= w_next;
    end

    // Next-state logic; abort beats skip beats timer expiry in PLAY
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_SPLASH: if (w_tick && w_start_seen) w_next = ST_PLAY;
            ST_PLAY: begin
                if (w_tick) begin
                    if (w_abort_seen)              w_next = ST_SPLASH;
                    else if (w_skip_seen)          w_next = ST_SAVE;
                    else if (r_frames_left <= 11'd1) w_next = ST_SAVE;
                end
            end
            ST_SAVE:   if (save_ack) w_next = ST_RESULT;
            ST_RESULT: begin
                if (w_tick) begin
                    if (w_start_seen)                      w_next = ST_PLAY;
                    else if (r_result_cnt == c_result_last) w_next = ST_SPLASH;
                end
            end
            default:   w_next = ST_SPLASH;
        endcase
    end

    // Pending code latches, pad history, score, round timer and result dwell
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_start_pend  <= 1'b0;
            r_skip_pend   <= 1'b0;
            r_abort_pend  <= 1'b0;
            r_pad_hist    <= 3'd0;
            r_score       <= 8'd0;
            r_frames_left <= 11'd0;
            r_result_cnt  <= 16'd0;
        end else begin
            if (w_state_change) begin
                r_start_pend <= 1'b0;
                r_skip_pend  <= 1'b0;
                r_abort_pend <= 1'b0;
            end else begin
                if (w_is_start && (r_state == ST_SPLASH || r_state == ST_RESULT))
                    r_start_pend <= 1'b1;
                if (w_is_skip && r_state == ST_PLAY)
                    r_skip_pend <= 1'b1;
                if (w_is_abort && r_state == ST_PLAY)
                    r_abort_pend <= 1'b1;
            end

            if (w_tick)
                r_pad_hist <= r_pads;

            // Hits on the tick that leaves PLAY are still scored
            if (w_tick && r_state == ST_PLAY) begin
                r_score <= w_score_sat;
                if (r_frames_left != 11'd0)
                    r_frames_left <= r_frames_left - 11'd1;
            end

            // Entering a round overrides the scoring update above
            if (w_next == ST_PLAY && r_state != ST_PLAY) begin
                r_score       <= 8'd0;
                r_frames_left <= c_game_frames;
            end

            if (r_state != ST_RESULT)
                r_result_cnt <= 16'd0;
            else if (w_tick)
                r_result_cnt <= r_result_cnt + 16'd1;
        end
    end

    assign screen               = r_state;
    assign score                = r_score;
    assign frames_left          = r_frames_left;
    assign save_signal          = (r_state == ST_SAVE);
    assign sensor_input_to_save = {16'h0, 8'd0, r_score};

endmodule
`default_nettype wire

// File: tb/tb_vga_screen_sequencer.sv
`default_nettype none
// ============================================================================
//  Module : tb_vga_screen_sequencer
//  Brief  : Directed self-checking bench. Instance A uses default parameters,
//           instance B uses a 4-frame round and 3-frame result dwell.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_vga_screen_sequencer;

    logic        clk;
    logic        vs;
    logic        rst_a, rst_b;
    logic [31:0] ctrl_a, ctrl_b, sens_a, sens_b;
    logic        ack_a, ack_b;
    logic [1:0]  scr_a, scr_b;
    logic [7:0]  score_a, score_b;
    logic [10:0] fl_a, fl_b;
    logic        save_a, save_b;
    logic [31:0] pay_a, pay_b;

    int checks = 0;
    int errors = 0;

    vga_screen_sequencer dut_a (
        .iVGA_CLK             (clk),
        .iRST_n               (rst_a),
        .iVS                  (vs),
        .controller           (ctrl_a),
        .sensor_input         (sens_a),
        .save_ack             (ack_a),
        .screen               (scr_a),
        .score                (score_a),
        .frames_left          (fl_a),
        .save_signal          (save_a),
        .sensor_input_to_save (pay_a)
    );

    vga_screen_sequencer #(.GAME_FRAMES(4), .RESULT_FRAMES(3)) dut_b (
        .iVGA_CLK             (clk),
        .iRST_n               (rst_b),
        .iVS                  (vs),
        .controller           (ctrl_b),
        .sensor_input         (sens_b),
        .save_ack             (ack_b),
        .screen               (scr_b),
        .score                (score_b),
        .frames_left          (fl_b),
        .save_signal          (save_b),
        .sensor_input_to_save (pay_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One video frame: sync high, then a falling edge and sync low
    task automatic do_frame();
        vs = 1'b1;
        cyc(3);
        vs = 1'b0;
        cyc(3);
    endtask

    task automatic test_reset();
        rst_a = 1'b0; rst_b = 1'b0; vs = 1'b0;
        ctrl_a = 0; ctrl_b = 0; sens_a = 0; sens_b = 0; ack_a = 0; ack_b = 0;
        cyc(2);
        checks++; if (scr_a !== 2'd0) begin errors++; $display("FAIL reset_screen: got %0d expected 0", scr_a); end
        checks++; if (score_a !== 8'd0) begin errors++; $display("FAIL reset_score: got %0d expected 0", score_a); end
        checks++; if (fl_a !== 11'd0) begin errors++; $display("FAIL reset_frames_left: got %0d expected 0", fl_a); end
        checks++; if (save_a !== 1'b0) begin errors++; $display("FAIL reset_save: got %0d expected 0", save_a); end
        checks++; if (pay_a !== 32'd0) begin errors++; $display("FAIL reset_payload: got %h expected 0", pay_a); end
        checks++; if (scr_b !== 2'd0) begin errors++; $display("FAIL reset_screen_b: got %0d expected 0", scr_b); end
        rst_a = 1'b1; rst_b = 1'b1;
        cyc(1);
        ctrl_a = 32'd2; cyc(1); ctrl_a = 0;
        ctrl_b = 32'h6; cyc(1); ctrl_b = 0;
        ack_b = 1'b1;   cyc(1); ack_b = 0;
        cyc(6);
        checks++; if (scr_a !== 2'd0) begin errors++; $display("FAIL no_tick_before_vs_high: got %0d expected 0", scr_a); end
    endtask

    task automatic test_start();
        vs = 1'b1;
        cyc(3);
        checks++; if (scr_a !== 2'd0) begin errors++; $display("FAIL start_mid_frame: got %0d expected 0", scr_a); end
        vs = 1'b0;
        cyc(3);
        checks++; if (scr_a !== 2'd1) begin errors++; $display("FAIL start_screen: got %0d expected 1", scr_a); end
        checks++; if (fl_a !== 11'd1800) begin errors++; $display("FAIL start_frames_left: got %0d expected 1800", fl_a); end
        checks++; if (score_a !== 8'd0) begin errors++; $display("FAIL start_score: got %0d expected 0", score_a); end
        checks++; if (scr_b !== 2'd0) begin errors++; $display("FAIL unlisted_code_ignored: got %0d expected 0", scr_b); end
    endtask

    task automatic test_hits();
        sens_a = (32'd1 << 1) | (32'd1 << 15);
        do_frame();
        checks++; if (score_a !== 8'd2) begin errors++; $display("FAIL hits_two_pads: got %0d expected 2", score_a); end
        sens_a = sens_a | (32'd1 << 8);
        do_frame();
        checks++; if (score_a !== 8'd3) begin errors++; $display("FAIL hits_third_pad: got %0d expected 3", score_a); end
        do_frame();
        do_frame();
        checks++; if (score_a !== 8'd3) begin errors++; $display("FAIL hits_held_no_inc: got %0d expected 3", score_a); end
        sens_a = 0;
        do_frame();
        checks++; if (score_a !== 8'd3) begin errors++; $display("FAIL hits_fall_no_inc: got %0d expected 3", score_a); end
        checks++; if (fl_a !== 11'd1795) begin errors++; $display("FAIL hits_frames_left: got %0d expected 1795", fl_a); end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 83; i++) begin
            sens_a = (32'd1 << 1) | (32'd1 << 8) | (32'd1 << 15);
            do_frame();
            sens_a = 0;
            do_frame();
        end
        checks++; if (score_a !== 8'd252) begin errors++; $display("FAIL sat_preload: got %0d expected 252", score_a); end
        sens_a = (32'd1 << 1) | (32'd1 << 8);
        do_frame();
        checks++; if (score_a !== 8'd254) begin errors++; $display("FAIL sat_254: got %0d expected 254", score_a); end
        sens_a = 0; do_frame();
        sens_a = (32'd1 << 1) | (32'd1 << 15);
        do_frame();
        checks++; if (score_a !== 8'd255) begin errors++; $display("FAIL sat_clip: got %0d expected 255", score_a); end
        sens_a = 0; do_frame();
        sens_a = (32'd1 << 1) | (32'd1 << 8) | (32'd1 << 15);
        do_frame();
        checks++; if (score_a !== 8'd255) begin errors++; $display("FAIL sat_hold: got %0d expected 255", score_a); end
        checks++; if (fl_a !== 11'd1624) begin errors++; $display("FAIL sat_frames_left: got %0d expected 1624", fl_a); end
        sens_a = 0;
    endtask

    task automatic test_abort();
        logic saw = 1'b0;
        ctrl_a = 32'd8;  cyc(1); saw = saw | save_a;
        ctrl_a = 32'd16; cyc(1); saw = saw | save_a;
        ctrl_a = 0;
        vs = 1'b1;
        for (int i = 0; i < 3; i++) begin cyc(1); saw = saw | save_a; end
        checks++; if (scr_a !== 2'd1) begin errors++; $display("FAIL abort_waits_tick: got %0d expected 1", scr_a); end
        vs = 1'b0;
        for (int i = 0; i < 4; i++) begin cyc(1); saw = saw | save_a; end
        checks++; if (scr_a !== 2'd0) begin errors++; $display("FAIL abort_screen: got %0d expected 0", scr_a); end
        checks++; if (saw !== 1'b0) begin errors++; $display("FAIL abort_no_save: got %0d expected 0", saw); end
    endtask

    task automatic test_expire();
        ctrl_b = 32'd4; cyc(1); ctrl_b = 0;
        do_frame();
        checks++; if (scr_b !== 2'd1) begin errors++; $display("FAIL exp_start: got %0d expected 1", scr_b); end
        checks++; if (fl_b !== 11'd4) begin errors++; $display("FAIL exp_load: got %0d expected 4", fl_b); end
        do_frame(); do_frame(); do_frame();
        checks++; if (fl_b !== 11'd1) begin errors++; $display("FAIL exp_count: got %0d expected 1", fl_b); end
        checks++; if (scr_b !== 2'd1) begin errors++; $display("FAIL exp_still_play: got %0d expected 1", scr_b); end
        sens_b = 32'd1 << 1;
        do_frame();
        checks++; if (scr_b !== 2'd2) begin errors++; $display("FAIL exp_save_screen: got %0d expected 2", scr_b); end
        checks++; if (save_b !== 1'b1) begin errors++; $display("FAIL exp_save_signal: got %0d expected 1", save_b); end
        checks++; if (fl_b !== 11'd0) begin errors++; $display("FAIL exp_frames_zero: got %0d expected 0", fl_b); end
        checks++; if (score_b !== 8'd1) begin errors++; $display("FAIL exp_last_tick_hit: got %0d expected 1", score_b); end
        checks++; if (pay_b !== 32'h1) begin errors++; $display("FAIL exp_payload: got %h expected 00000001", pay_b); end
        ctrl_b = 32'd16; cyc(1); ctrl_b = 32'd8; cyc(1); ctrl_b = 0;
        do_frame();
        cyc(10);
        checks++; if (scr_b !== 2'd2) begin errors++; $display("FAIL save_ignores_codes: got %0d expected 2", scr_b); end
        checks++; if (save_b !== 1'b1) begin errors++; $display("FAIL save_held: got %0d expected 1", save_b); end
        checks++; if (pay_b !== 32'h1) begin errors++; $display("FAIL payload_stable: got %h expected 00000001", pay_b); end
        ack_b = 1'b1; cyc(1); ack_b = 0;
        checks++; if (save_b !== 1'b0) begin errors++; $display("FAIL ack_drops_save: got %0d expected 0", save_b); end
        checks++; if (scr_b !== 2'd3) begin errors++; $display("FAIL ack_result: got %0d expected 3", scr_b); end
    endtask

    task automatic test_result();
        do_frame(); do_frame();
        checks++; if (scr_b !== 2'd3) begin errors++; $display("FAIL result_dwell: got %0d expected 3", scr_b); end
        do_frame();
        checks++; if (scr_b !== 2'd0) begin errors++; $display("FAIL result_to_splash: got %0d expected 0", scr_b); end
        ctrl_b = 32'd2; cyc(1); ctrl_b = 0;
        do_frame();
        ctrl_b = 32'd8; cyc(1); ctrl_b = 0;
        do_frame();
        checks++; if (scr_b !== 2'd2) begin errors++; $display("FAIL skip_to_save: got %0d expected 2", scr_b); end
        ack_b = 1'b1; cyc(1); ack_b = 0;
        ctrl_b = 32'd4; cyc(1); ctrl_b = 0;
        do_frame();
        checks++; if (scr_b !== 2'd1) begin errors++; $display("FAIL result_start: got %0d expected 1", scr_b); end
        checks++; if (fl_b !== 11'd4) begin errors++; $display("FAIL result_start_load: got %0d expected 4", fl_b); end
        checks++; if (score_b !== 8'd0) begin errors++; $display("FAIL result_start_score: got %0d expected 0", score_b); end
    endtask

    task automatic test_reset_save();
        ctrl_b = 32'd8; cyc(1); ctrl_b = 0;
        do_frame();
        checks++; if (save_b !== 1'b1) begin errors++; $display("FAIL rs_in_save: got %0d expected 1", save_b); end
        @(posedge clk); #1;
        rst_b = 1'b0;
        #2;
        checks++; if (save_b !== 1'b0) begin errors++; $display("FAIL rs_async_save: got %0d expected 0", save_b); end
        checks++; if (scr_b !== 2'd0) begin errors++; $display("FAIL rs_async_screen: got %0d expected 0", scr_b); end
        checks++; if (fl_b !== 11'd0) begin errors++; $display("FAIL rs_async_frames: got %0d expected 0", fl_b); end
        cyc(2);
        rst_b = 1'b1;
        ctrl_b = 32'd2; cyc(1); ctrl_b = 0;
        cyc(8);
        checks++; if (scr_b !== 2'd0) begin errors++; $display("FAIL rs_no_tick_low_vs: got %0d expected 0", scr_b); end
        do_frame();
        checks++; if (scr_b !== 2'd1) begin errors++; $display("FAIL rs_tick_after_high: got %0d expected 1", scr_b); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_hits();
        test_saturate();
        test_abort();
        test_expire();
        test_result();
        test_reset_save();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_screen_sequencer.md
VGA_SCREEN_SEQUENCER -- requirements
Module: vga_screen_sequencer

Interface
REQ-001 SHALL have parameter GAME_FRAMES, default 1800, meaning play-round length in frames (30 s at 60 Hz).
REQ-002 SHALL have parameter RESULT_FRAMES, default 300, meaning result-screen dwell in frames before returning to splash.
REQ-003 SHALL have port iVGA_CLK  in  1  pixel clock; all logic SHALL be clocked on its rising edge.
REQ-004 SHALL have port iRST_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port iVS  in  1  active-low vertical sync from the sync generator; a 1->0 transition marks a frame boundary.
REQ-006 SHALL have port controller  in  32  one-hot button code from the processor: 2 or 4 = start, 8 = skip to result, 16 = abort.
REQ-007 SHALL have port sensor_input  in  32  pad hit flags; bits 1, 8 and 15 = pads 0, 1 and 2.
REQ-008 SHALL have port save_ack  in  1  one-cycle acknowledge from the memory-write side.
REQ-009 SHALL have port screen  out  2  screen select: 0 SPLASH, 1 PLAY, 2 SAVE, 3 RESULT.
REQ-010 SHALL have port score  out  8  hits in the current or last round.
REQ-011 SHALL have port frames_left  out  11  remaining play frames.
REQ-012 SHALL have port save_signal  out  1  save request.
REQ-013 SHALL have port sensor_input_to_save  out  32  save payload {16'h0, 8'd0, score}.

Function
REQ-014 SHALL register iVS, controller and sensor_input once each cycle, and SHALL detect a frame tick as registered iVS 1 followed by iVS 0; the tick SHALL be one cycle wide.
REQ-015 SHALL implement FSM states SPLASH, PLAY, SAVE and RESULT, with screen equal to the encoding of the current state.
REQ-016 SHALL commit SPLASH->PLAY only on a frame tick, and only if a start code was seen in any cycle since the previous tick (latched pending flag).
REQ-017 On entering PLAY, SHALL clear score to 0 and load frames_left with GAME_FRAMES.
REQ-018 In PLAY, SHALL decrement frames_left by 1 per frame tick; when a tick occurs with frames_left==1, SHALL set frames_left to 0 and move to SAVE.
REQ-019 In PLAY, SHALL latch a skip code (8) and move to SAVE on the next tick; this SHALL take priority over timer expiry on the same tick.
REQ-020 In PLAY, SHALL latch an abort code (16) and move to SPLASH on the next tick without saving; abort SHALL beat skip and expiry.
REQ-021 In PLAY, SHALL detect rising edges of pad bits (1, 8, 15) against the value sampled at the previous frame tick, evaluating per tick, and SHALL add the count of rising pads (0-3) to score.
REQ-022 score SHALL saturate at 255 and never wrap.
REQ-023 Hit edges detected on the tick that leaves PLAY SHALL still be counted.
REQ-024 In SAVE, SHALL assert save_signal from the first SAVE cycle and hold it, with a stable payload, until the cycle save_ack is sampled high.
REQ-025 In SAVE, the cycle after save_ack SHALL deassert save_signal and enter RESULT; save_ack outside SAVE SHALL be ignored.
REQ-026 In SAVE, SHALL ignore controller codes and frame ticks.
REQ-027 In RESULT, SHALL count RESULT_FRAMES ticks and then return to SPLASH; a start code SHALL instead go directly to PLAY on the next tick.
REQ-028 The controller value 0 and any non-listed codes SHALL be ignored in every state.
REQ-029 Pending code latches SHALL clear on every state change.

Reset
REQ-030 Asserting iRST_n low at any time, including mid-SAVE, SHALL immediately force SPLASH, screen=0, score=0, frames_left=0, save_signal=0, payload=0 and all latches/edge history to 0.
REQ-031 After iRST_n deasserts, the first frame tick SHALL NOT be generated until iVS has been sampled high at least once.

Structure
REQ-032 State encoding, controller code constants and pad bit indices SHALL live in shared package vga_game_pkg, also used by vga_controller.
REQ-033 Frame-tick detection SHALL be a sub-module vga_frame_tick (registered edge detector).

Verification
REQ-034 Reset, then controller=2 mid-frame -> screen stays 0 until next iVS fall, then screen=1, frames_left=1800, score=0.
REQ-035 PLAY, bits 1 and 15 rise before a tick, bit 8 rises before the next tick -> score=2, then score=3; holding the bits high for further ticks -> no further increments.
REQ-036 GAME_FRAMES=4, no input -> SAVE after the 4th tick, save_signal=1; save_ack held low for 10 cycles, then pulsed -> save_signal=0 the next cycle, screen=3.
REQ-037 PLAY with controller=8 and 16 pulsed in the same frame -> screen=0 at the tick, save_signal never asserted.
REQ-038 score preloaded near 254 by 2 rising pads on one tick -> score=255, and it stays 255 on further hits.
REQ-039 iRST_n pulsed low during SAVE -> save_signal=0 and screen=0 asynchronously; no frame tick until iVS is seen high.
